// File: rtl/mem_ie_seq.sv
// mem_ie_seq: memory-stage exception sequencer.
// Takes one access, presents its start and then its end address to the
// segment-limit/TLB check unit, and returns a one-hot exception class and
// the faulting address over a valid/ready response channel.
// Optional build macro MEM_IE_PERF_EN adds saturating protection and
// page-fault counters (cnt_prot, cnt_pf).
module mem_ie_seq #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_seg_max,
    output logic [ADDR_W-1:0] chk_addr,
    output logic [ADDR_W-1:0] chk_seg_max,
    input  logic              chk_seg_ex,
    input  logic              chk_tlb_hit,
    input  logic              intr_pending,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [2:0]        resp_ie_type,
    output logic [ADDR_W-1:0] resp_fault_addr
`ifdef MEM_IE_PERF_EN
    ,
    output logic [15:0]       cnt_prot,
    output logic [15:0]       cnt_pf
`endif
);

    localparam logic [2:0] IE_NONE = 3'b000;
    localparam logic [2:0] IE_PROT = 3'b001;
    localparam logic [2:0] IE_PF   = 3'b010;
    localparam logic [2:0] IE_INTR = 3'b100;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHK_START = 2'd1,
        CHK_END   = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Last byte of the access, one bit wider so a wrap past the top of the
    // address space shows up in the MSB.
    function automatic logic [ADDR_W:0] last_byte(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0]        sz);
        logic [ADDR_W:0] span;
        span = (ADDR_W+1)'(1) << sz;
        return {1'b0, a} + span - (ADDR_W+1)'(1);
    endfunction

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [ADDR_W:0]   end_q;
    logic              prot0_q;
    logic              pf0_q;

    logic              load_req;
    logic              go_end;
    logic              finish;
    logic              fire;

    logic              p0, f0, p1, f1;
    logic [2:0]        ie_nxt;
    logic [ADDR_W-1:0] fa_nxt;

    assign resp_valid = (state_q == RESP);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        load_req  = 1'b0;
        go_end    = 1'b0;
        finish    = 1'b0;
        fire      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    load_req = 1'b1;
                    state_d  = CHK_START;
                end
            end
            CHK_START: begin
                if (size_q == 2'b00) begin
                    finish  = 1'b1;
                    state_d = RESP;
                end else begin
                    go_end  = 1'b1;
                    state_d = CHK_END;
                end
            end
            CHK_END: begin
                finish  = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    fire    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fault resolution for the last check cycle: start before end within a
    // class, protection before page fault, interrupt only when clean.
    always_comb begin
        p0     = chk_seg_ex;
        f0     = ~chk_tlb_hit;
        p1     = 1'b0;
        f1     = 1'b0;
        ie_nxt = IE_NONE;
        fa_nxt = '0;
        if (state_q == CHK_END) begin
            p0 = prot0_q;
            f0 = pf0_q;
            p1 = chk_seg_ex | end_q[ADDR_W];
            f1 = ~chk_tlb_hit;
        end
        if (p0) begin
            ie_nxt = IE_PROT;
            fa_nxt = addr_q;
        end else if (p1) begin
            ie_nxt = IE_PROT;
            fa_nxt = end_q[ADDR_W-1:0];
        end else if (f0) begin
            ie_nxt = IE_PF;
            fa_nxt = addr_q;
        end else if (f1) begin
            ie_nxt = IE_PF;
            fa_nxt = end_q[ADDR_W-1:0];
        end else if (intr_pending) begin
            ie_nxt = IE_INTR;
        end
    end

    // Access capture, check-unit drive and registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q          <= '0;
            size_q          <= '0;
            end_q           <= '0;
            prot0_q         <= 1'b0;
            pf0_q           <= 1'b0;
            chk_addr        <= '0;
            chk_seg_max     <= '0;
            resp_ie_type    <= IE_NONE;
            resp_fault_addr <= '0;
        end else begin
            if (load_req) begin
                addr_q      <= req_addr;
                size_q      <= req_size;
                end_q       <= last_byte(req_addr, req_size);
                chk_addr    <= req_addr;
                chk_seg_max <= req_seg_max;
            end
            if (go_end) begin
                prot0_q  <= chk_seg_ex;
                pf0_q    <= ~chk_tlb_hit;
                chk_addr <= end_q[ADDR_W-1:0];
            end
            if (finish) begin
                resp_ie_type    <= ie_nxt;
                resp_fault_addr <= fa_nxt;
            end
            if (fire) begin
                resp_ie_type    <= IE_NONE;
                resp_fault_addr <= '0;
            end
        end
    end

`ifdef MEM_IE_PERF_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Exception counters, bumped on each delivered protection / page fault
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_prot <= '0;
            cnt_pf   <= '0;
        end else if (fire) begin
            if (resp_ie_type == IE_PROT) cnt_prot <= sat_inc(cnt_prot);
            if (resp_ie_type == IE_PF)   cnt_pf   <= sat_inc(cnt_pf);
        end
    end
`endif

endmodule

// File: tb/tb_mem_ie_seq.sv
// Directed testbench for mem_ie_seq with a reference model of the exception
// rules and a check-unit stand-in (limit compare plus a two-entry miss list).
module tb_mem_ie_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_seg_max;
    logic [31:0] chk_addr;
    logic [31:0] chk_seg_max;
    logic        chk_seg_ex;
    logic        chk_tlb_hit;
    logic        intr_pending;
    logic        resp_valid;
    logic        resp_ready;
    logic [2:0]  resp_ie_type;
    logic [31:0] resp_fault_addr;
`ifdef MEM_IE_PERF_EN
    logic [15:0] cnt_prot;
    logic [15:0] cnt_pf;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] miss0, miss1;
    logic        miss0_en, miss1_en;

    logic        exp_active = 1'b0;
    logic [2:0]  exp_ie;
    logic [31:0] exp_fa;
    int          exp_cnt_prot = 0;
    int          exp_cnt_pf   = 0;

    always #5 clk = ~clk;

    // Check-unit stand-in: limit exceeded when address is above segment max
    assign chk_seg_ex  = (chk_addr > chk_seg_max);
    assign chk_tlb_hit = !((miss0_en && chk_addr == miss0) || (miss1_en && chk_addr == miss1));

    mem_ie_seq dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_size       (req_size),
        .req_seg_max    (req_seg_max),
        .chk_addr       (chk_addr),
        .chk_seg_max    (chk_seg_max),
        .chk_seg_ex     (chk_seg_ex),
        .chk_tlb_hit    (chk_tlb_hit),
        .intr_pending   (intr_pending),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_ie_type   (resp_ie_type),
        .resp_fault_addr(resp_fault_addr)
`ifdef MEM_IE_PERF_EN
        ,
        .cnt_prot       (cnt_prot),
        .cnt_pf         (cnt_pf)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic bit tlb_miss(input logic [31:0] a);
        return (miss0_en && a == miss0) || (miss1_en && a == miss1);
    endfunction

    // Reference: list the addresses touched, find the first protection fault,
    // else the first page fault, else interrupt, else clean.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [1:0] sz,
                                          input logic [31:0] smax, input bit intr_last);
        logic [32:0] last;
        logic [31:0] ad [2];
        bit          prot [2];
        bit          pf   [2];
        int          n;
        last  = {1'b0, a} + (33'd1 << sz) - 33'd1;
        n     = (sz == 2'b00) ? 1 : 2;
        ad[0] = a;
        ad[1] = last[31:0];
        for (int i = 0; i < 2; i++) begin
            prot[i] = (i < n) && ((ad[i] > smax) || (i == 1 && last[32]));
            pf[i]   = (i < n) && tlb_miss(ad[i]);
        end
        for (int i = 0; i < 2; i++) if (prot[i]) return {3'b001, ad[i]};
        for (int i = 0; i < 2; i++) if (pf[i])   return {3'b010, ad[i]};
        if (intr_last) return {3'b100, 32'h0};
        return 35'h0;
    endfunction

    // Compare process: every cycle a response is visible it must match the
    // outstanding expectation and the request side must be closed.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (!exp_active) begin
                check("spurious_resp_valid", 64'(resp_valid), 64'(0));
            end else begin
                check("resp_ie_type", 64'(resp_ie_type), 64'(exp_ie));
                check("resp_fault_addr", 64'(resp_fault_addr), 64'(exp_fa));
                check("req_ready_in_resp", 64'(req_ready), 64'(0));
            end
        end
    end

    task automatic set_miss(input logic e0, input logic [31:0] a0,
                            input logic e1, input logic [31:0] a1);
        miss0_en = e0; miss0 = a0;
        miss1_en = e1; miss1 = a1;
    endtask

    // intr_mode: 0 none, 1 held through both check cycles, 2 only in CHK_START
    task automatic do_access(input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] smax, input int intr_mode, input int hold,
                             input logic [2:0] lit_ie, input logic [31:0] lit_fa);
        logic [34:0] m;
        logic [31:0] last;
        bit          intr_last;
        int          n;
        intr_last = (sz == 2'b00) ? (intr_mode != 0) : (intr_mode == 1);
        m = model(a, sz, smax, intr_last);
        check("model_ie", 64'(m[34:32]), 64'(lit_ie));
        check("model_fa", 64'(m[31:0]), 64'(lit_fa));
        exp_ie = lit_ie;
        exp_fa = lit_fa;
        last   = a + (32'd1 << sz) - 32'd1;

        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", 64'(req_ready), 64'(1));
        req_valid   = 1'b1;
        req_addr    = a;
        req_size    = sz;
        req_seg_max = smax;
        @(negedge clk);
        // CHK_START cycle
        req_valid    = 1'b0;
        exp_active   = 1'b1;
        intr_pending = (intr_mode != 0);
        check("chk_addr_start", 64'(chk_addr), 64'(a));
        check("chk_seg_max", 64'(chk_seg_max), 64'(smax));
        check("resp_valid_early", 64'(resp_valid), 64'(0));
        check("req_ready_busy", 64'(req_ready), 64'(0));
        if (sz != 2'b00) begin
            @(negedge clk);
            // CHK_END cycle
            intr_pending = (intr_mode == 1);
            check("chk_addr_end", 64'(chk_addr), 64'(last));
            check("resp_valid_early", 64'(resp_valid), 64'(0));
        end
        @(negedge clk);
        intr_pending = 1'b0;
        check("resp_valid_latency", 64'(resp_valid), 64'(1));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("resp_valid_hold", 64'(resp_valid), 64'(1));
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        exp_active = 1'b0;
        if (lit_ie == 3'b001) exp_cnt_prot++;
        if (lit_ie == 3'b010) exp_cnt_pf++;
        check("resp_valid_after_hs", 64'(resp_valid), 64'(0));
        check("ie_cleared_after_hs", 64'(resp_ie_type), 64'(0));
        check("fa_cleared_after_hs", 64'(resp_fault_addr), 64'(0));
        check("req_ready_after_hs", 64'(req_ready), 64'(1));
`ifdef MEM_IE_PERF_EN
        check("cnt_prot", 64'(cnt_prot), 64'(exp_cnt_prot));
        check("cnt_pf", 64'(cnt_pf), 64'(exp_cnt_pf));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_size     = '0;
        req_seg_max  = '0;
        intr_pending = 1'b0;
        resp_ready   = 1'b0;
        set_miss(1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_ie_type", 64'(resp_ie_type), 64'(0));
        check("rst_fault_addr", 64'(resp_fault_addr), 64'(0));
        check("rst_chk_addr", 64'(chk_addr), 64'(0));
        check("rst_chk_seg_max", 64'(chk_seg_max), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Clean 1B access
        do_access(32'h0000_1000, 2'b00, 32'h0000_2000, 0, 0, 3'b000, 32'h0);
        // 4B crossing the segment limit at the end
        do_access(32'h0000_1FFE, 2'b10, 32'h0000_2000, 0, 0, 3'b001, 32'h0000_2001);
        // 8B, TLB miss on end only
        set_miss(1'b1, 32'h0000_4003, 1'b0, 32'h0);
        do_access(32'h0000_3FFC, 2'b11, 32'hFFFF_0000, 0, 0, 3'b010, 32'h0000_4003);
        // 4B wrapping past the top, TLB miss on start: wrap protection wins
        set_miss(1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0);
        do_access(32'hFFFF_FFFE, 2'b10, 32'hFFFF_FFFF, 0, 0, 3'b001, 32'h0000_0001);
        set_miss(1'b0, 32'h0, 1'b0, 32'h0);
        // 2B clean with interrupt, response stalled 5 cycles
        do_access(32'h0000_5000, 2'b01, 32'h0000_6000, 1, 5, 3'b100, 32'h0);
        // Interrupt only in CHK_START of a 2B access is not sampled
        do_access(32'h0000_5000, 2'b01, 32'h0000_6000, 2, 0, 3'b000, 32'h0);
        // Interrupt in CHK_START of a 1B access is sampled
        do_access(32'h0000_5000, 2'b00, 32'h0000_6000, 2, 1, 3'b100, 32'h0);
        // Protection at both addresses: start reported
        do_access(32'h0000_7000, 2'b10, 32'h0000_6000, 0, 0, 3'b001, 32'h0000_7000);
        // Page fault at both addresses: start reported
        set_miss(1'b1, 32'h0000_8000, 1'b1, 32'h0000_8001);
        do_access(32'h0000_8000, 2'b01, 32'hFFFF_FFFF, 0, 0, 3'b010, 32'h0000_8000);
        // End protection beats start page fault
        set_miss(1'b1, 32'h0000_1FFE, 1'b0, 32'h0);
        do_access(32'h0000_1FFE, 2'b10, 32'h0000_2000, 1, 2, 3'b001, 32'h0000_2001);
        set_miss(1'b0, 32'h0, 1'b0, 32'h0);

        // Reset pulsed during CHK_END discards the access
        req_valid   = 1'b1;
        req_addr    = 32'h0000_9000;
        req_size    = 2'b01;
        req_seg_max = 32'h0000_A000;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("chk_addr_before_rst", 64'(chk_addr), 64'(32'h0000_9001));
        rst = 1'b1;
        #1;
        check("midrst_resp_valid", 64'(resp_valid), 64'(0));
        check("midrst_req_ready", 64'(req_ready), 64'(1));
        check("midrst_ie_type", 64'(resp_ie_type), 64'(0));
        exp_cnt_prot = 0;
        exp_cnt_pf   = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("no_resp_after_rst", 64'(resp_valid), 64'(0));
        do_access(32'h0000_1000, 2'b10, 32'h0000_2000, 0, 0, 3'b000, 32'h0);

        // Three protection faults back to back
        for (int i = 0; i < 3; i++)
            do_access(32'h0001_0000 + 32'(i), 2'b00, 32'h0000_2000, 0, 0, 3'b001,
                      32'h0001_0000 + 32'(i));
`ifdef MEM_IE_PERF_EN
        check("cnt_prot_final", 64'(cnt_prot), 64'(3));
        check("cnt_pf_final", 64'(cnt_pf), 64'(0));
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
